// File: rtl/cpu_hdr_pkg.sv
// rtl/cpu_hdr_pkg.sv - shared types and constants for the CPU header inserter
package cpu_hdr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } hdr_state_t;

   localparam int C_HDR_BEATS_MAX = 4;
   localparam int C_HDR_IDX_W     = $clog2(C_HDR_BEATS_MAX);

   // Bit offsets of metadata fields inside the header image, decoded by host software
   localparam int HDR_OFF_PORT   = 0;
   localparam int HDR_W_PORT     = 16;
   localparam int HDR_OFF_TSTAMP = 16;
   localparam int HDR_W_TSTAMP   = 64;
   localparam int HDR_OFF_QID    = 80;
   localparam int HDR_W_QID      = 8;

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry skid buffer with fully registered output side
module axis_skid_buf #(
   parameter int C_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [C_WIDTH-1:0] s_tdata,
   input  logic               s_tvalid,
   output logic               s_tready,
   output logic [C_WIDTH-1:0] m_tdata,
   output logic               m_tvalid,
   input  logic               m_tready
);

   logic [C_WIDTH-1:0] skid_data;
   logic               skid_valid;
   logic               push;
   logic               load_main;

   assign push      = s_tvalid && s_tready;
   // The output register may take a new word when it is empty or being drained
   assign load_main = !m_tvalid || m_tready;

   // Output register refills from the skid entry first, then from the input;
   // ready is registered and reflects only whether the skid entry is free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
         s_tready   <= 1'b0;
      end else begin
         if (load_main) begin
            if (skid_valid) begin
               m_tdata    <= skid_data;
               m_tvalid   <= 1'b1;
               skid_valid <= 1'b0;
            end else begin
               if (push) begin
                  m_tdata <= s_tdata;
               end
               m_tvalid <= push;
            end
            s_tready <= 1'b1;
         end else begin
            if (push) begin
               skid_data  <= s_tdata;
               skid_valid <= 1'b1;
            end
            s_tready <= !(skid_valid || push);
         end
      end
   end

endmodule

// File: rtl/cpu_header_insert.sv
// rtl/cpu_header_insert.sv - prepends a tuser-derived metadata header to CPU-bound packets
module cpu_header_insert
   import cpu_hdr_pkg::*;
#(
   parameter int C_DATA_WIDTH  = 256,
   parameter int C_TUSER_WIDTH = 128,
   parameter int C_HDR_BEATS   = 1,
   parameter int C_CNT_WIDTH   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_bypass,
   input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic [C_CNT_WIDTH-1:0]    stat_pkt_cnt
);

   localparam int C_KEEP_W = C_DATA_WIDTH / 8;
   localparam int C_HDR_W  = C_HDR_BEATS * C_DATA_WIDTH;
   localparam int C_SKID_W = C_DATA_WIDTH + C_KEEP_W + 1;

   hdr_state_t               state;
   logic [C_HDR_IDX_W-1:0]   idx;
   logic [C_TUSER_WIDTH-1:0] tuser_reg;

   logic [C_DATA_WIDTH-1:0]  hdr_first;
   logic [C_HDR_W-1:0]       hdr_held;
   logic [C_DATA_WIDTH-1:0]  hdr_beat;

   logic                     int_valid;
   logic                     int_ready;
   logic                     int_accept;
   logic [C_DATA_WIDTH-1:0]  int_tdata;
   logic [C_KEEP_W-1:0]      int_tkeep;
   logic                     int_tlast;
   logic [C_SKID_W-1:0]      skid_out;

   // Header beat 0 comes straight from live tuser so the header costs no extra cycle
   always_comb begin
      hdr_first = '0;
      for (int b = 0; b < C_DATA_WIDTH && b < C_TUSER_WIDTH; b++) begin
         hdr_first[b] = s_axis_tuser[b];
      end
   end

   // Later header beats come from the metadata latched at SOP
   always_comb begin
      hdr_held = '0;
      hdr_held[C_TUSER_WIDTH-1:0] = tuser_reg;
      hdr_beat = '0;
      for (int k = 0; k < C_HDR_BEATS; k++) begin
         if (idx == C_HDR_IDX_W'(k)) begin
            hdr_beat = hdr_held[k*C_DATA_WIDTH +: C_DATA_WIDTH];
         end
      end
   end

   // Select what feeds the skid buffer and when the upstream payload is consumed
   always_comb begin
      int_valid     = 1'b0;
      int_tdata     = s_axis_tdata;
      int_tkeep     = s_axis_tkeep;
      int_tlast     = s_axis_tlast;
      s_axis_tready = 1'b0;
      case (state)
         ST_IDLE: begin
            int_valid = s_axis_tvalid;
            if (cfg_bypass) begin
               s_axis_tready = int_ready;
            end else begin
               int_tdata = hdr_first;
               int_tkeep = '1;
               int_tlast = 1'b0;
            end
         end
         ST_HDR: begin
            int_valid = 1'b1;
            int_tdata = hdr_beat;
            int_tkeep = '1;
            int_tlast = 1'b0;
         end
         ST_BODY: begin
            int_valid     = s_axis_tvalid;
            s_axis_tready = int_ready;
         end
         default: ;
      endcase
   end

   assign int_accept = int_valid && int_ready;

   // Packet framing: IDLE decides header vs bypass at SOP, HDR walks the latched header
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         tuser_reg <= '0;
      end else if (int_accept) begin
         case (state)
            ST_IDLE: begin
               if (cfg_bypass) begin
                  if (!s_axis_tlast) begin
                     state <= ST_BODY;
                  end
               end else begin
                  tuser_reg <= s_axis_tuser;
                  idx       <= (C_HDR_BEATS > 1) ? C_HDR_IDX_W'(1) : '0;
                  state     <= (C_HDR_BEATS > 1) ? ST_HDR : ST_BODY;
               end
            end
            ST_HDR: begin
               if (idx == C_HDR_IDX_W'(C_HDR_BEATS - 1)) begin
                  idx   <= '0;
                  state <= ST_BODY;
               end else begin
                  idx <= idx + C_HDR_IDX_W'(1);
               end
            end
            ST_BODY: begin
               if (s_axis_tlast) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   axis_skid_buf #(
      .C_WIDTH (C_SKID_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  ({int_tlast, int_tkeep, int_tdata}),
      .s_tvalid (int_valid),
      .s_tready (int_ready),
      .m_tdata  (skid_out),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready)
   );

   assign m_axis_tdata = skid_out[C_DATA_WIDTH-1:0];
   assign m_axis_tkeep = skid_out[C_DATA_WIDTH +: C_KEEP_W];
   assign m_axis_tlast = skid_out[C_SKID_W-1];

   // Count packets as their last beat leaves on the master side
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_pkt_cnt <= '0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         stat_pkt_cnt <= stat_pkt_cnt + C_CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_cpu_header_insert.sv
// tb/tb_cpu_header_insert.sv - self-checking bench for cpu_header_insert
module tb_cpu_header_insert;

   localparam int DW = 256;
   localparam int KW = 32;
   localparam int UW = 384;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   typedef struct {
      int            d;
      int            n;
      logic [UW-1:0] tu;
      logic          bp;
      bit            tog;
      int            exp_len;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [DW-1:0] s_tdata  [2];
   logic [UW-1:0] s_tuser  [2];
   logic [KW-1:0] s_tkeep  [2];
   logic          s_tvalid [2];
   logic          s_tlast  [2];
   logic          byp      [2];
   logic          m_tready [2];

   logic          a_s_tready, a_m_tvalid, a_m_tlast, b_s_tready, b_m_tvalid, b_m_tlast;
   logic [DW-1:0] a_m_tdata, b_m_tdata;
   logic [KW-1:0] a_m_tkeep, b_m_tkeep;
   logic [31:0]   a_stat, b_stat;

   logic          o_s_tready [2];
   logic          o_m_tvalid [2];
   logic          o_m_tlast  [2];
   logic [DW-1:0] o_m_tdata  [2];
   logic [KW-1:0] o_m_tkeep  [2];
   logic [31:0]   o_stat     [2];

   cpu_header_insert #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(128), .C_HDR_BEATS(1), .C_CNT_WIDTH(32)) dut_a (
      .clk(clk), .rst(rst), .cfg_bypass(byp[0]),
      .s_axis_tdata(s_tdata[0]), .s_axis_tuser(s_tuser[0][127:0]), .s_axis_tkeep(s_tkeep[0]),
      .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tready(a_s_tready),
      .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
      .m_axis_tlast(a_m_tlast), .m_axis_tready(m_tready[0]), .stat_pkt_cnt(a_stat));

   cpu_header_insert #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW), .C_HDR_BEATS(2), .C_CNT_WIDTH(32)) dut_b (
      .clk(clk), .rst(rst), .cfg_bypass(byp[1]),
      .s_axis_tdata(s_tdata[1]), .s_axis_tuser(s_tuser[1]), .s_axis_tkeep(s_tkeep[1]),
      .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tready(b_s_tready),
      .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
      .m_axis_tlast(b_m_tlast), .m_axis_tready(m_tready[1]), .stat_pkt_cnt(b_stat));

   always_comb begin
      o_s_tready[0] = a_s_tready; o_s_tready[1] = b_s_tready;
      o_m_tvalid[0] = a_m_tvalid; o_m_tvalid[1] = b_m_tvalid;
      o_m_tlast[0]  = a_m_tlast;  o_m_tlast[1]  = b_m_tlast;
      o_m_tdata[0]  = a_m_tdata;  o_m_tdata[1]  = b_m_tdata;
      o_m_tkeep[0]  = a_m_tkeep;  o_m_tkeep[1]  = b_m_tkeep;
      o_stat[0]     = a_stat;     o_stat[1]     = b_stat;
   end

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t q0[$];
   beat_t q1[$];
   int    exp_pkts[2];
   int    cur_len[2];
   int    last_len[2];
   int    cyc = 0;
   bit    span_on = 0;
   int    span_first, span_last, span_n;
   bit    rnd_ready = 0;
   bit    indep_chk = 0;
   logic  rdy_before;
   beat_t mon_e;
   vec_t  tbl[7];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int hb(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic void qpush(input int d, input beat_t b);
      if (d == 0) q0.push_back(b); else q1.push_back(b);
   endfunction

   function automatic beat_t qpop(input int d);
      if (d == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] v;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [UW-1:0] rand_tuser();
      logic [UW-1:0] v;
      for (int i = 0; i < UW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every accepted output beat must be the next one the model predicts
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (o_m_tvalid[d] && m_tready[d]) begin
               if (qsize(d) == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_beat dut%0d: got %h expected none", d, o_m_tdata[d]);
               end else begin
                  mon_e = qpop(d);
                  check("m_tdata", o_m_tdata[d], mon_e.data);
                  check("m_tkeep", DW'(o_m_tkeep[d]), DW'(mon_e.keep));
                  check("m_tlast", DW'(o_m_tlast[d]), DW'(mon_e.last));
               end
               if (span_on && d == 1) begin
                  if (span_n == 0) span_first = cyc;
                  span_last = cyc;
                  span_n++;
               end
               cur_len[d]++;
               if (o_m_tlast[d]) begin
                  last_len[d] = cur_len[d];
                  cur_len[d] = 0;
               end
            end
         end
      end
   end

   // Output backpressure; in random mode also proves s_tready ignores same-cycle m_tready
   initial begin
      m_tready[0] = 1'b1;
      m_tready[1] = 1'b1;
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) m_tready[d] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (indep_chk && !rst) begin
            rdy_before = o_s_tready[0];
            #1 m_tready[0] = !m_tready[0];
            #1 check("s_tready_indep_of_m_tready", DW'(o_s_tready[0]), DW'(rdy_before));
            m_tready[0] = !m_tready[0];
         end
      end
   end

   // Queue expectations from the packet description, then push the beats upstream
   task automatic send_pkt(input int d, input int n, input logic [UW-1:0] tu, input logic bp,
                           input bit tog, input bit scramble, input bit no_last);
      logic [4*DW-1:0] hdr;
      beat_t b;
      int t;
      bit hs;
      hdr = '0;
      if (d == 0) hdr[127:0] = tu[127:0]; else hdr[UW-1:0] = tu;
      if (!bp) begin
         for (int k = 0; k < hb(d); k++) begin
            b.data = hdr[k*DW +: DW]; b.keep = '1; b.last = 1'b0;
            qpush(d, b);
         end
      end
      for (int i = 0; i < n; i++) begin
         b.data = rand_data();
         b.keep = (i == n-1) ? ($urandom | 32'h1) : '1;
         b.last = (i == n-1) && !no_last;
         qpush(d, b);
         s_tdata[d] = b.data; s_tkeep[d] = b.keep; s_tlast[d] = b.last; s_tvalid[d] = 1'b1;
         if (i == 0) begin
            s_tuser[d] = tu; byp[d] = bp;
         end else begin
            if (tog) byp[d] = !bp;
            if (scramble) s_tuser[d] = rand_tuser();
         end
         t = 0;
         do begin
            @(negedge clk);
            hs = o_s_tready[d];
            @(posedge clk); #1;
            t++;
            if (scramble) s_tuser[d] = rand_tuser();
         end while (!hs && t < 200);
         if (!hs) begin
            n_cmp++; n_err++;
            $display("FAIL handshake_timeout dut%0d beat %0d: got no s_tready expected within 200 cycles", d, i);
         end
      end
      s_tvalid[d] = 1'b0;
      s_tlast[d] = 1'b0;
      if (!no_last) exp_pkts[d]++;
   endtask

   task automatic drain(input int d);
      int t = 0;
      while (qsize(d) != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (qsize(d) != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout dut%0d: got %0d beats pending expected 0", d, qsize(d));
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_m_tvalid"}, DW'(o_m_tvalid[d]), '0);
         check({tag, "_m_tdata"}, o_m_tdata[d], '0);
         check({tag, "_m_tkeep"}, DW'(o_m_tkeep[d]), '0);
         check({tag, "_m_tlast"}, DW'(o_m_tlast[d]), '0);
         check({tag, "_s_tready"}, DW'(o_s_tready[d]), '0);
         check({tag, "_stat"}, DW'(o_stat[d]), '0);
      end
   endtask

   initial begin
      #1_000_000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      logic [UW-1:0] tu_fixed;
      for (int d = 0; d < 2; d++) begin
         s_tdata[d] = '0; s_tuser[d] = '0; s_tkeep[d] = '0;
         s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0; byp[d] = 1'b0;
         exp_pkts[d] = 0; cur_len[d] = 0; last_len[d] = 0;
      end
      span_n = 0; span_first = 0; span_last = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      tu_fixed = {128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978,
                  128'hfeed_face_cafe_beef_1111_2222_3333_4444,
                  128'h8877_6655_4433_2211_a5a5_5a5a_c3c3_3c3c};
      tbl[0] = '{0, 3, UW'(32'h1234), 1'b0, 1'b0, 4};
      tbl[1] = '{0, 1, UW'(64'hdead_beef_0bad_f00d), 1'b0, 1'b0, 2};
      tbl[2] = '{0, 4, UW'(32'h5555), 1'b1, 1'b1, 4};
      tbl[3] = '{0, 2, UW'(32'h7777), 1'b0, 1'b0, 3};
      tbl[4] = '{1, 1, tu_fixed, 1'b0, 1'b0, 3};
      tbl[5] = '{1, 3, tu_fixed, 1'b1, 1'b0, 3};
      tbl[6] = '{1, 2, ~tu_fixed, 1'b0, 1'b1, 4};
      for (int i = 0; i < 7; i++) begin
         send_pkt(tbl[i].d, tbl[i].n, tbl[i].tu, tbl[i].bp, tbl[i].tog, 1'b0, 1'b0);
         drain(tbl[i].d);
         check("pkt_len", DW'(last_len[tbl[i].d]), DW'(tbl[i].exp_len));
         check("stat_pkt_cnt", DW'(o_stat[tbl[i].d]), DW'(exp_pkts[tbl[i].d]));
      end

      // Back-to-back single-beat packets with two header beats: 9 beats in 9 cycles
      span_n = 0;
      span_on = 1'b1;
      for (int p = 0; p < 3; p++) send_pkt(1, 1, rand_tuser(), 1'b0, 1'b0, 1'b0, 1'b0);
      drain(1);
      span_on = 1'b0;
      check("b2b_beats", DW'(span_n), DW'(9));
      check("b2b_no_bubble", DW'(span_last - span_first + 1), DW'(9));

      // tuser scrambled every cycle after SOP acceptance; header must keep the SOP value
      send_pkt(1, 2, tu_fixed, 1'b0, 1'b0, 1'b1, 1'b0);
      drain(1);
      check("scramble_stat", DW'(o_stat[1]), DW'(exp_pkts[1]));

      // Random traffic under 50% backpressure
      rnd_ready = 1'b1;
      indep_chk = 1'b1;
      for (int p = 0; p < 100; p++) begin
         send_pkt(0, $urandom_range(1, 5), rand_tuser(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      drain(0);
      indep_chk = 1'b0;
      rnd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("random_stat", DW'(o_stat[0]), DW'(exp_pkts[0]));
      check("random_pkts_sent", DW'(exp_pkts[0]), DW'(104));

      // Reset in the middle of the payload of packet 2
      rst = 1'b1;
      #1;
      rst = 1'b0;
      exp_pkts[0] = 0; exp_pkts[1] = 0;
      q0.delete(); q1.delete();
      cur_len[0] = 0; cur_len[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      send_pkt(0, 3, rand_tuser(), 1'b0, 1'b0, 1'b0, 1'b0);
      drain(0);
      check("pkt1_stat", DW'(o_stat[0]), DW'(1));
      send_pkt(0, 2, rand_tuser(), 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midpkt_reset");
      q0.delete();
      exp_pkts[0] = 0;
      cur_len[0] = 0;
      @(posedge clk); #1;
      check("midpkt_reset_hold_m_tvalid", DW'(o_m_tvalid[0]), '0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_pkt(0, 3, UW'(32'h4242), 1'b0, 1'b0, 1'b0, 1'b0);
      drain(0);
      check("resume_pkt_len", DW'(last_len[0]), DW'(4));
      check("resume_stat", DW'(o_stat[0]), DW'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
